neo_strand_ctrl_p: RTL
======================

NEO_STRAND_CTRL_P -- requirements
Module: neo_strand_ctrl_p

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 5, meaning the number of pixels on the strand (1..64).
REQ-002 SHALL have parameter NUM_COLORS, default 3, meaning the channels per pixel (3 = GRB, 4 = GRBW); other values are illegal.
REQ-003 SHALL have parameters T0H=18, T1H=35, TBIT=63 and TRST=2500, meaning clock counts at 50 MHz for 0-high, 1-high, bit period and latch low.
REQ-004 SHALL have port: clock  input  1  system clock, rising edge.
REQ-005 SHALL have port: reset  input  1  one clock; reset is synchronous and active-low.
REQ-006 SHALL have port: load_color  input  1  write color_level into pixel_index/color_index.
REQ-007 SHALL have port: pixel_index  input  $clog2(NUM_PIXELS) (min 1)  target pixel.
REQ-008 SHALL have port: color_index  input  2  0=G, 1=R, 2=B, 3=W.
REQ-009 SHALL have port: color_level  input  8  channel intensity.
REQ-010 SHALL have port: send_it  input  1  start frame transmission.
REQ-011 SHALL have port: brightness  input  8  global scale for the frame.
REQ-012 SHALL have port: ready_to_load  output  1  load_color accepted this cycle.
REQ-013 SHALL have port: ready_to_send  output  1  send_it accepted this cycle.
REQ-014 SHALL have port: neo_data  output  1  serial strand data.
REQ-015 SHALL have port: frame_done  output  1  one-cycle pulse at end of latch.

Function
REQ-016 SHALL implement states IDLE, SEND, LATCH; ready_to_load = ready_to_send = (state==IDLE).
REQ-017 SHALL, in IDLE with load_color=1, write color_level to the addressed entry at the next edge; writes with pixel_index>=NUM_PIXELS or color_index>=NUM_COLORS are dropped.
REQ-018 SHALL ignore load_color and send_it outside IDLE.
REQ-019 SHALL, on send_it in IDLE, capture brightness and enter SEND next cycle; when load_color and send_it occur together, the write SHALL be included in that frame.
REQ-020 SHALL transmit pixel 0 first, channels in index order 0..NUM_COLORS-1, each byte MSB first; total NUM_PIXELS*NUM_COLORS*8 bits.
REQ-021 SHALL transmit byte = (color_level * (brightness+1)) >> 8, 16-bit product, upper 8 bits; brightness=255 passes levels unchanged, brightness=0 maps 255 to 0.
REQ-022 SHALL drive each bit high for T0H (bit 0) or T1H (bit 1) clocks, then low for the remainder of TBIT clocks; bits are back-to-back with no gap.
REQ-023 SHALL, after the last bit's TBIT period, enter LATCH with neo_data=0 for TRST clocks, then IDLE.
REQ-024 SHALL assert frame_done for exactly the one cycle on which the FSM is in LATCH with its counter at TRST-1.
REQ-025 SHALL drive neo_data=0 in IDLE and LATCH.
REQ-026 SHALL leave pixel memory unchanged by transmission; a second send_it resends the same data.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, enter IDLE, clear all pixel memory to 0, and set neo_data=0, frame_done=0, ready_to_load=ready_to_send=1.
REQ-028 SHALL abort any frame or latch in progress on reset; neo_data SHALL be 0 from the next edge.

Structure
REQ-029 SHALL take from shared package neo_pkg: the color-index enum (GREEN, RED, BLUE, WHITE), the fsm state typedef, and the default timing constants.
REQ-030 SHALL place bit timing (T0H/T1H/TBIT counter, bit-done strobe) in sub-module neo_bit_encoder.

Verification
REQ-031 SHALL verify: reset, load pixel0 G=0xAA, send_it with brightness=255 -> first 8 bits are 1,0,1,0,1,0,1,0 with highs of 35/18 clocks and 63-clock periods.
REQ-032 SHALL verify: NUM_PIXELS=5, NUM_COLORS=3, send_it -> exactly 120 bits, then 2500 low clocks, a single frame_done pulse, and ready_to_send high the following cycle.
REQ-033 SHALL verify: NUM_COLORS=4, load pixel 2 W=0xFF, brightness=127 -> W byte is 0x7F and the frame is 160 bits.
REQ-034 SHALL verify: load_color during SEND (pixel0 R=0x55) -> ignored; the next frame still shows the old R value.
REQ-035 SHALL verify: load pixel_index=5 with NUM_PIXELS=5, and color_index=3 with NUM_COLORS=3 -> no memory change.
REQ-036 SHALL verify: reset=0 at bit 40 of a frame -> neo_data=0 next edge, IDLE, and a subsequent send outputs all-zero bits.

Source files
------------

// File: rtl/neo_pkg.sv
// Shared definitions for the NeoPixel strand controller: channel indices,
// sequencer states, default 50 MHz timing and the brightness scaler.
package neo_pkg;

  typedef enum logic [1:0] {
    GREEN = 2'd0,
    RED   = 2'd1,
    BLUE  = 2'd2,
    WHITE = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int DEF_T0H  = 18;
  localparam int DEF_T1H  = 35;
  localparam int DEF_TBIT = 63;
  localparam int DEF_TRST = 2500;

  // Upper byte of level * (bright + 1); bright = 255 is unity gain.
  function automatic logic [7:0] scale_level(input logic [7:0] level,
                                             input logic [7:0] bright);
    logic [15:0] prod;
    prod = 16'(level) * (16'(bright) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// Single-wire bit encoder: one TBIT-long period per bit, high for T0H or
// T1H clocks at the start. Periods abut while run stays high.
module neo_bit_encoder
  import neo_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic bit_val,
  output logic neo_data,
  output logic bit_done
);

  localparam int CW = $clog2(TBIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] hi_floor;

  // Period down-counter; reloads on terminal count so bits are back-to-back.
  always_ff @(posedge clock) begin
    if (!reset || !run) begin
      cnt_q <= CW'(TBIT - 1);
    end else if (cnt_q == '0) begin
      cnt_q <= CW'(TBIT - 1);
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // The line is high while the count is still above the bit's low portion.
  assign hi_floor = bit_val ? CW'(TBIT - T1H) : CW'(TBIT - T0H);
  assign neo_data = run && (cnt_q >= hi_floor);
  assign bit_done = run && (cnt_q == '0);

endmodule

// File: rtl/neo_strand_ctrl_p.sv
// NeoPixel strand controller: pixel memory, frame sequencer and latch timer.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | accepts loads and send_it, line held low
//   SEND  | shifting pixel bytes out MSB first through the encoder
//   LATCH | line low for TRST clocks, frame_done on the final cycle
module neo_strand_ctrl_p
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int NUM_COLORS = 3,
  parameter int T0H        = DEF_T0H,
  parameter int T1H        = DEF_T1H,
  parameter int TBIT       = DEF_TBIT,
  parameter int TRST       = DEF_TRST,
  localparam int PW        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_color,
  input  logic [PW-1:0] pixel_index,
  input  logic [1:0]    color_index,
  input  logic [7:0]    color_level,
  input  logic          send_it,
  input  logic [7:0]    brightness,
  output logic          ready_to_load,
  output logic          ready_to_send,
  output logic          neo_data,
  output logic          frame_done
);

  localparam int LW = $clog2(TRST + 1);

  state_e        state_q;
  logic [7:0]    mem [NUM_PIXELS][NUM_COLORS];
  logic [PW-1:0] pix_q;
  color_e        col_q;
  logic [2:0]    bitn_q;
  logic [7:0]    bright_q;
  logic [7:0]    byte_q;
  logic [LW-1:0] lcnt_q;
  logic          frame_done_q;

  logic          wr_en;
  logic          last_col;
  logic          last_pix;
  logic          bit_done;
  logic          enc_data;
  logic [PW-1:0] nxt_pix;
  color_e        nxt_col;
  logic [7:0]    nxt_level;
  logic [7:0]    first_level;

  assign wr_en = (state_q == IDLE) && load_color &&
                 (int'(pixel_index) < NUM_PIXELS) &&
                 (int'(color_index) < NUM_COLORS);

  assign last_col = (col_q == color_e'(NUM_COLORS - 1));
  assign last_pix = (pix_q == PW'(NUM_PIXELS - 1));

  // Address of the byte that follows the current one; wraps to 0 after the
  // final byte so the lookup always stays inside the memory.
  assign nxt_col   = last_col ? GREEN : color_e'(col_q + 2'd1);
  assign nxt_pix   = last_col ? (last_pix ? '0 : pix_q + PW'(1)) : pix_q;
  assign nxt_level = mem[nxt_pix][nxt_col];

  // A write landing on the same edge as send_it must reach the first byte.
  assign first_level = (wr_en && (pixel_index == '0) && (color_index == GREEN)) ?
                       color_level : mem[0][0];

  // Pixel memory: cleared on reset, written only while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < NUM_COLORS; c++) begin
          mem[p][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[pixel_index][color_index] <= color_level;
    end
  end

  // Frame sequencer: walks pixel/channel/bit, then times the latch gap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      col_q        <= GREEN;
      bitn_q       <= 3'd7;
      bright_q     <= '0;
      byte_q       <= '0;
      lcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send_it) begin
            state_q  <= SEND;
            bright_q <= brightness;
            pix_q    <= '0;
            col_q    <= GREEN;
            bitn_q   <= 3'd7;
            byte_q   <= scale_level(first_level, brightness);
          end
        end
        SEND: begin
          if (bit_done) begin
            if (bitn_q == 3'd0) begin
              bitn_q <= 3'd7;
              pix_q  <= nxt_pix;
              col_q  <= nxt_col;
              byte_q <= scale_level(nxt_level, bright_q);
              if (last_col && last_pix) begin
                state_q <= LATCH;
                lcnt_q  <= '0;
              end
            end else begin
              bitn_q <= bitn_q - 3'd1;
              byte_q <= {byte_q[6:0], 1'b0};
            end
          end
        end
        LATCH: begin
          if (lcnt_q == LW'(TRST - 1)) begin
            state_q <= IDLE;
          end else begin
            lcnt_q <= lcnt_q + LW'(1);
          end
          // Registered one cycle early so the pulse sits on lcnt == TRST-1.
          if (lcnt_q == LW'(TRST - 2)) begin
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  neo_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_enc (
    .clock    (clock),
    .reset    (reset),
    .run      (state_q == SEND),
    .bit_val  (byte_q[7]),
    .neo_data (enc_data),
    .bit_done (bit_done)
  );

  assign ready_to_load = (state_q == IDLE);
  assign ready_to_send = (state_q == IDLE);
  assign neo_data      = enc_data;
  assign frame_done    = frame_done_q;

endmodule
